// File: rtl/mux4src_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-source mux arbiter.
package mux4src_pkg;

  localparam int unsigned NUM_SRC = 4;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_0    = 4'b0001;
  localparam logic [3:0] SEL_1    = 4'b0010;
  localparam logic [3:0] SEL_2    = 4'b0100;
  localparam logic [3:0] SEL_3    = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_GRANT
  } state_e;

  // Index of the set bit in a one-hot select; 0 when no bit is set.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4src_rr_arbiter_if.sv
// Handshake bundle between the requesters/consumer and the arbiter.
interface mux4src_rr_arbiter_if;
  import mux4src_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] last;
  logic               dst_ready;
  logic [NUM_SRC-1:0] sel;
  logic [NUM_SRC-1:0] ack;
  logic               out_valid;
  logic               busy;

  // Arbiter side.
  modport master (
    input  req, last, dst_ready,
    output sel, ack, out_valid, busy
  );

  // Requester / consumer side.
  modport slave (
    output req, last, dst_ready,
    input  sel, ack, out_valid, busy
  );

endinterface

// File: rtl/mux4src_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set req bit starting at ptr, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic       any
);

  logic [1:0] idx;

  // Scan ptr, ptr+1, ... and grant the first requester found.
  always_comb begin
    grant = 4'b0000;
    any   = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4src_rr_arbiter.sv
// Round-robin arbiter sharing a 4-source one-hot mux; grant is held for a burst.
module mux4src_rr_arbiter
  import mux4src_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux4src_rr_arbiter_if.master  bus
);

  state_e             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               out_valid_q;

  logic [1:0]         g;
  logic [3:0]         ack;
  logic               accepted;
  logic               release_now;
  logic [3:0]         pick_req;
  logic [1:0]         pick_ptr;
  logic [3:0]         pick_grant;
  logic               pick_any;

  assign g        = onehot_to_idx(sel_q);
  // sel_q is zero outside GRANT, so this also forces ack low in IDLE.
  assign ack      = sel_q & bus.req & {NUM_SRC{bus.dst_ready}};
  assign accepted = |ack;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Release on withdrawal, on an accepted last beat, or when the burst limit is hit.
  always_comb begin
    release_now = 1'b0;
    if (state_q == ST_GRANT) begin
      release_now = !(|(sel_q & bus.req)) ||
                    (accepted && ((|(ack & bus.last)) || (cnt_inc == CNT_W'(BURST_MAX))));
    end
  end

  // One picker serves both the IDLE pick and the handover pick (releaser masked out).
  always_comb begin
    pick_req = bus.req;
    pick_ptr = ptr_q;
    if (state_q == ST_GRANT) begin
      pick_req = bus.req & ~sel_q;
      pick_ptr = g + 2'd1;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Next-state logic for grant ownership, rotation pointer and beat count.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          sel_d   = pick_grant;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_d = pick_ptr;
          cnt_d = '0;
          if (pick_any) begin
            sel_d = pick_grant;
          end else begin
            state_d = ST_IDLE;
            sel_d   = SEL_NONE;
          end
        end else if (accepted) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  // State registers; out_valid tracks the mux's one-cycle registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_NONE;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= accepted;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.ack       = ack;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ST_GRANT);

endmodule
